// File: rtl/uart_tx_arbiter_pkg.sv
// Shared FSM state type and frame constants for the UART TX arbiter.
// UART_TX_ARBITER_PARITY_EN selects 11-bit frames with an even-parity bit.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOCKED,
      ST_SEND
   } arb_state_e;

   localparam logic [7:0] LF = 8'h0A;

`ifdef UART_TX_ARBITER_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   // Bits that follow the start bit, bit 0 transmitted first.
   function automatic logic [FRAME_BITS-2:0] frame_payload(input logic [7:0] data);
`ifdef UART_TX_ARBITER_PARITY_EN
      return {1'b1, ^data, data};
`else
      return {1'b1, data};
`endif
   endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// UART bit serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Frame length follows UART_TX_ARBITER_PARITY_EN through the package.
module uart_tx_ser
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   logic [BAUD_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-2:0] shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         busy     <= 1'b0;
         tx       <= 1'b1;
      end else if (start) begin
         shreg    <= frame_payload(data);
         baud_cnt <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b1;
         tx       <= 1'b0;
      end else if (busy) begin
         if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
               busy <= 1'b0;
               tx   <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               tx      <= shreg[0];
               shreg   <= {1'b0, shreg[FRAME_BITS-2:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

   // Raised one cycle before the stop bit ends so a new start can follow with no gap.
   always_comb begin
      done = busy && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_PRE);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line; a grant locks the line until LF or timeout.
// UART_TX_ARBITER_PARITY_EN (see package) adds an even-parity bit to each frame.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned LOCK_TIMEOUT = 65536
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ-1:0][7:0]    req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic                       tx_o,
   output logic [$clog2(NUM_REQ)-1:0] owner_o,
   output logic                       locked_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   arb_state_e       state, state_next;
   logic [IDX_W-1:0] owner, rr_ptr, grant_idx, sel, cand_idx;
   logic [CNT_W-1:0] idle_cnt;
   logic             lf_sent, grant_found, accept;
   logic [7:0]       sel_data;
   logic             ser_busy, ser_done;
   int unsigned      cand;

   // rr_ptr holds the highest-priority index, i.e. one past the last owner.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = i + 32'(rr_ptr);
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!grant_found && req_valid_i[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_next  = state;
      req_ready_o = '0;
      accept      = 1'b0;
      sel         = owner;
      case (state)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready_o[grant_idx] = 1'b1;
               accept                 = 1'b1;
               sel                    = grant_idx;
               state_next             = ST_SEND;
            end
         end
         ST_LOCKED: begin
            req_ready_o[owner] = 1'b1;
            if (req_valid_i[owner]) begin
               accept     = 1'b1;
               state_next = ST_SEND;
            end else if (!ser_busy && idle_cnt == CNT_LAST) begin
               state_next = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (ser_done) state_next = lf_sent ? ST_IDLE : ST_LOCKED;
         end
         default: state_next = ST_IDLE;
      endcase
      sel_data = req_data_i[sel];
   end

   // The idle count starts once the stop bit has fully left the line.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         idle_cnt <= '0;
         lf_sent  <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            owner    <= sel;
            rr_ptr   <= (sel == IDX_LAST) ? '0 : sel + 1'b1;
            lf_sent  <= (sel_data == LF);
            idle_cnt <= '0;
         end else if (state == ST_LOCKED && state_next == ST_LOCKED && !ser_busy) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else if (state_next != ST_LOCKED) begin
            idle_cnt <= '0;
         end
      end
   end

   uart_tx_ser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .start(accept),
      .data (sel_data),
      .busy (ser_busy),
      .done (ser_done),
      .tx   (tx_o)
   );

   always_comb begin
      owner_o  = owner;
      locked_o = (state != ST_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed waveform, lock and reset cases plus
// randomized multi-requester traffic against a line-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned CPB = 4;
   localparam int unsigned LTO = 16;
`ifdef UART_TX_ARBITER_PARITY_EN
   localparam int unsigned FB = 11;
`else
   localparam int unsigned FB = 10;
`endif
   localparam int unsigned FRAME_CYC = FB * CPB;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0]  b;
      logic [1:0]  own;
      int unsigned t0;
      logic        ok;
   } rx_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NR-1:0]        valid = '0;
   logic [NR-1:0][7:0]   data = '0;
   logic [NR-1:0]        ready;
   logic                 tx;
   logic [1:0]           owner;
   logic                 locked;

   int checks = 0;
   int errors = 0;

   bq_t src_q[NR];
   rx_t rx_q[$];
   rx_t exp_q[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ     (NR),
      .CLKS_PER_BIT(CPB),
      .LOCK_TIMEOUT(LTO)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(valid),
      .req_data_i (data),
      .req_ready_o(ready),
      .tx_o       (tx),
      .owner_o    (owner),
      .locked_o   (locked)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (FB == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   // Line receiver: samples mid-bit, records byte, owner at start, start cycle, framing.
   int unsigned cyc = 0, mt = 0, mt0 = 0, bitk = 0;
   logic mbusy = 1'b0, mok = 1'b1;
   logic [7:0] msh = '0;
   logic [1:0] mown = '0;
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         mbusy = 1'b0;
      end else if (!mbusy) begin
         if (tx === 1'b0) begin
            mbusy = 1'b1; mt = 0; msh = '0; mok = 1'b1; mown = owner; mt0 = cyc;
         end
      end else begin
         mt++;
      end
      if (mbusy && rst_n && (mt % CPB) == CPB / 2) begin
         bitk = mt / CPB;
         if (bitk == 0) mok = mok & (tx === 1'b0);
         else if (bitk <= 8) msh[bitk-1] = tx;
         else if (bitk == FB - 1) begin
            mok = mok & (tx === 1'b1);
            rx_q.push_back('{b: msh, own: mown, t0: mt0, ok: mok});
            mbusy = 1'b0;
         end else mok = mok & (tx === ^msh);
      end
   end

   // Whole lines are served in round-robin order starting from requester 0 after reset.
   task automatic build_expect();
      bq_t         m[NR];
      int unsigned p;
      int          found;
      logic [7:0]  b;
      p = 0;
      exp_q.delete();
      for (int r = 0; r < NR; r++) m[r] = src_q[r];
      forever begin
         found = -1;
         for (int i = 0; i < NR; i++)
            if (found < 0 && m[(p + i) % NR].size() > 0) found = int'((p + i) % NR);
         if (found < 0) break;
         do begin
            b = m[found].pop_front();
            exp_q.push_back('{b: b, own: 2'(found), t0: 0, ok: 1'b1});
         end while (b != 8'h0A && m[found].size() > 0);
         p = (found + 1) % NR;
      end
   endtask

   task automatic run_lines(input string tag, input int unsigned budget, input bit gaps,
                            input bit spacing);
      int unsigned gap[NR];
      bit          acc[NR];
      int unsigned n, total, lim;
      logic [7:0]  b;
      build_expect();
      total = exp_q.size();
      n = 0;
      for (int r = 0; r < NR; r++) begin gap[r] = 0; acc[r] = 0; end
      while (n < budget && rx_q.size() < total) begin
         @(negedge clk);
         for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
               b = src_q[r].pop_front();
               if (gaps && b != 8'h0A) gap[r] = $urandom_range(0, 3);
            end else if (gap[r] > 0) begin
               gap[r]--;
            end
            valid[r] = (src_q[r].size() > 0) && (gap[r] == 0);
            data[r]  = valid[r] ? src_q[r][0] : 8'($urandom);
         end
         #1;
         check({tag, "_onehot"}, 32'($countones(ready) <= 1), 1);
         for (int r = 0; r < NR; r++) acc[r] = valid[r] & ready[r];
         n++;
      end
      valid = '0;
      check({tag, "_in_budget"}, 32'(n < budget), 1);
      check({tag, "_count"}, rx_q.size(), total);
      lim = (rx_q.size() < total) ? rx_q.size() : total;
      for (int unsigned i = 0; i < lim; i++) begin
         check($sformatf("%s_byte%0d", tag, i), rx_q[i].b, exp_q[i].b);
         check($sformatf("%s_owner%0d", tag, i), rx_q[i].own, exp_q[i].own);
         check($sformatf("%s_frame%0d", tag, i), rx_q[i].ok, 1);
         if (spacing && i > 0)
            check($sformatf("%s_gap%0d", tag, i), rx_q[i].t0 - rx_q[i-1].t0, FRAME_CYC);
      end
   endtask

   task automatic do_reset();
      valid = '0;
      data  = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete();
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      logic [7:0]  b;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready", ready, 0);
      check("rst_locked", locked, 0);
      check("rst_owner", owner, 0);

      // Single byte 8'h41 from requester 0: exact waveform, then lock timeout
      do_reset();
      valid[0] = 1'b1; data[0] = 8'h41;
      #1 check("grant0", ready, 4'b0001);
      @(negedge clk);
      valid[0] = 1'b0; data[0] = 8'hFF;
      for (int unsigned k = 0; k < FRAME_CYC; k++) begin
         check($sformatf("tx41_c%0d", k), tx, frame_bit(8'h41, k / CPB));
         if (k == 3 * CPB) check("send_ready_low", ready, 0);
         @(negedge clk);
      end
      check("after41_tx", tx, 1);
      check("after41_locked", locked, 1);
      check("after41_owner", owner, 0);
      n = 0;
      while (locked === 1'b1 && n < 4 * LTO) begin @(negedge clk); n++; end
      check("release_cycles", n, LTO);

      // Owner 3 holds the lock while requester 0 waits
      do_reset();
      valid[3] = 1'b1; data[3] = 8'h58;
      #1 check("grant3", ready, 4'b1000);
      @(negedge clk);
      valid[3] = 1'b0; valid[0] = 1'b1; data[0] = 8'h33;
      check("owner3", owner, 3);
      n = 0;
      while (ready[0] !== 1'b1 && n < 4 * FRAME_CYC) begin @(negedge clk); n++; end
      check("wait0_cycles", n, FRAME_CYC + LTO);
      check("wait0_unlocked", locked, 0);
      check("wait0_ready", ready, 4'b0001);
      @(negedge clk);
      valid[0] = 1'b0;
      check("owner0_after", owner, 0);
      check("locked0_after", locked, 1);
      check("rx58_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("rx58_byte", rx_q[0].b, 8'h58);

      // Reset during data bit 3, then a clean frame
      do_reset();
      valid[0] = 1'b1; data[0] = 8'hC3;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (CPB * 4 + 1) @(negedge clk);
      check("midframe_tx", tx, frame_bit(8'hC3, 4));
      rst_n = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_locked", locked, 0);
      check("abort_owner", owner, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete();
      valid[2] = 1'b1; data[2] = 8'h0A;
      #1 check("post_rst_grant", ready, 4'b0100);
      @(negedge clk);
      valid[2] = 1'b0;
      for (int unsigned k = 0; k < FRAME_CYC; k++) begin
         check($sformatf("tx0a_c%0d", k), tx, frame_bit(8'h0A, k / CPB));
         @(negedge clk);
      end
      check("lf_unlocked", locked, 0);
      check("post_rst_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("post_rst_byte", rx_q[0].b, 8'h0A);

      // Requesters 1 and 2 stream "AB\n" together
      do_reset();
      src_q[1] = '{8'h41, 8'h42, 8'h0A};
      src_q[2] = '{8'h41, 8'h42, 8'h0A};
      run_lines("ab", 1000, 1'b0, 1'b1);

      // All four continuously offering LF bytes: rotation with no starvation
      do_reset();
      for (int r = 0; r < NR; r++) src_q[r] = '{8'h0A, 8'h0A};
      run_lines("rot", 1500, 1'b0, 1'b1);

      // Randomized lines with mid-line valid gaps
      for (int it = 0; it < 3; it++) begin
         do_reset();
         for (int r = 0; r < NR; r++) begin
            src_q[r].delete();
            if ($urandom_range(0, 3) != 0) begin
               for (int l = 0; l < int'($urandom_range(1, 2)); l++) begin
                  for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                     b = 8'($urandom);
                     if (b == 8'h0A) b = 8'h0B;
                     src_q[r].push_back(b);
                  end
                  src_q[r].push_back(8'h0A);
               end
            end
         end
         run_lines($sformatf("rnd%0d", it), 6000, 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the UART line (2..16).
REQ-002 Parameter CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200); minimum 2.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: idle cycles after which an owner's line lock is released.
REQ-004 Port clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_ni  in  1: reset, asynchronous, active-low.
REQ-006 Port req_valid_i  in  NUM_REQ: per-requester byte valid.
REQ-007 Port req_data_i  in  NUM_REQ x 8: per-requester byte.
REQ-008 Port req_ready_o  out  NUM_REQ: per-requester byte accept.
REQ-009 Port tx_o  out  1: serial UART line, idle high.
REQ-010 Port owner_o  out  clog2(NUM_REQ): index of the current lock owner; valid only while locked_o is high.
REQ-011 Port locked_o  out  1: a requester holds the line lock.

Function
REQ-012 A byte SHALL transfer when req_valid_i[i] and req_ready_o[i] are both high on a rising edge; at most one req_ready_o bit SHALL be high in any cycle.
REQ-013 Arbiter FSM states SHALL be IDLE, LOCKED and SEND.
REQ-014 IDLE: a round-robin grant SHALL be made among the valid requesters, starting after the last owner; the grant SHALL assert req_ready_o for that requester in the same cycle (combinational), and acceptance moves the FSM to SEND with locked_o=1.
REQ-015 SEND: the serializer SHALL emit start bit 0, data bits LSB first, then stop bit 1, each bit held exactly CLKS_PER_BIT cycles; tx_o SHALL fall on the cycle after acceptance.
REQ-016 At the end of the stop bit, the FSM SHALL go to IDLE if the sent byte was 8'h0A, and to LOCKED otherwise.
REQ-017 LOCKED: only the owner's req_ready_o SHALL be asserted; other requesters SHALL wait, so lines never interleave.
REQ-018 LOCKED: the idle counter SHALL increment each cycle the owner's valid is low, and clear on acceptance; reaching LOCK_TIMEOUT-1 SHALL release the lock to IDLE.
REQ-019 req_ready_o SHALL be low throughout SEND; back-to-back bytes SHALL have zero idle bit-times between the stop bit and the next start bit.
REQ-020 A request dropping valid without a handshake SHALL be legal and SHALL NOT corrupt state.
REQ-021 A byte whose req_data_i changes after acceptance SHALL be sent unchanged, because it is registered at acceptance.

Reset
REQ-022 On rst_ni low: FSM=IDLE, tx_o=1, req_ready_o=0, locked_o=0, owner_o=0, round-robin pointer=0, counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with tx_o high; no partial byte is resumed.

Configuration
REQ-024 Macro UART_TX_ARBITER_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL be inserted between the last data bit and the stop bit, giving 11-bit frames; when undefined, frames SHALL be 10 bits with no parity logic present.

Structure
REQ-025 Package uart_tx_arbiter_pkg SHALL hold the FSM state enum, the LF constant 8'h0A and the FRAME_BITS constant (10/11, macro-dependent).
REQ-026 Sub-module uart_tx_ser SHALL hold the bit serializer (baud counter, bit counter, shift register), with ports start/data/busy/done/tx; the arbiter holds the FSM, round-robin and timeout logic.

Verification (CLKS_PER_BIT=4, NUM_REQ=4, LOCK_TIMEOUT=16)
REQ-027 Requester 0 sends 8'h41 -> tx_o low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; 40 cycles total (44 with parity, parity bit 0).
REQ-028 Requesters 1 and 2 each stream "AB\n" simultaneously -> line carries "AB\nAB\n" with requester 1's line complete first; owner_o switches only after 8'h0A.
REQ-029 Owner 3 sends 8'h58 then goes idle while requester 0 waits -> lock released exactly 16 cycles after the stop bit ends; requester 0 is then granted.
REQ-030 rst_ni pulsed low during data bit 3 -> tx_o=1 and locked_o=0 on the same edge; the next frame after reset is clean.
REQ-031 All four requesters continuously valid with bytes 8'h0A -> grants in rotation 0,1,2,3,0 with no requester starved.
